// File: rtl/stoch_sat_addsub_multi_if.sv
// Lane-bank bus for the multi-channel stochastic saturating add/subtract block.
// The master drives operands/controls; the slave returns the registered results.
interface stoch_sat_addsub_multi_if #(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_SIZE = 8
);
   logic                             EN;
   logic [NUM_CH-1:0]                MODE;
   logic [NUM_CH-1:0]                a;
   logic [NUM_CH-1:0]                b;
   logic [NUM_CH-1:0]                CLR_SAT;
   logic [NUM_CH-1:0]                y;
   logic [NUM_CH-1:0]                sat;
   logic [NUM_CH*COUNTER_SIZE-1:0]   count;

   modport master (output EN, MODE, a, b, CLR_SAT, input y, sat, count);
   modport slave  (input EN, MODE, a, b, CLR_SAT, output y, sat, count);
endinterface

// File: rtl/stoch_sat_addsub_multi.sv
// NUM_CH independent lanes computing max(a-b,0) or min(a+b,1) on stochastic bitstreams.
// One-cycle latency, one bit per lane per cycle, all outputs registered.
module stoch_sat_addsub_multi #(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_SIZE = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   stoch_sat_addsub_multi_if.slave io
);
   localparam int CW = COUNTER_SIZE;

   logic [CW-1:0]     cnt_q  [NUM_CH];
   logic [CW-1:0]     cnt_d  [NUM_CH];
   logic [CW+1:0]     step_r [NUM_CH];
   logic [NUM_CH-1:0] mode_q, mode_d;
   logic [NUM_CH-1:0] y_q, y_d;
   logic [NUM_CH-1:0] sat_q, sat_d;

   // Returns {y, sat_set, next_cnt} for one lane given the effective count.
   function automatic logic [CW+1:0] lane_step(input logic m, input logic ai,
                                               input logic bi, input logic [CW-1:0] c);
      logic [CW-1:0] n;
      logic          yy;
      logic          ss;
      logic          inc;
      n   = c;
      yy  = 1'b0;
      ss  = 1'b0;
      inc = 1'b0;
      if (!m) begin
         if (ai && !bi) begin
            if (c == '0) yy = 1'b1;
            else         n  = c - CW'(1);
         end else if (!ai && bi) begin
            inc = 1'b1;
         end
      end else begin
         if (ai && bi) begin
            yy  = 1'b1;
            inc = 1'b1;
         end else if (ai != bi) begin
            yy = 1'b1;
         end else if (c != '0) begin
            yy = 1'b1;
            n  = c - CW'(1);
         end
      end
      if (inc) begin
         if (&c) ss = 1'b1;
         else    n  = c + CW'(1);
      end
      return {yy, ss, n};
   endfunction

   always_comb begin
      mode_d = mode_q;
      y_d    = '0;
      sat_d  = sat_q & ~io.CLR_SAT;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]  = cnt_q[i];
         // A mode change discards whatever carry the lane was holding.
         step_r[i] = lane_step(io.MODE[i], io.a[i], io.b[i],
                               (io.MODE[i] != mode_q[i]) ? '0 : cnt_q[i]);
         if (io.EN) begin
            cnt_d[i]  = step_r[i][CW-1:0];
            y_d[i]    = step_r[i][CW+1];
            mode_d[i] = io.MODE[i];
            sat_d[i]  = sat_d[i] | step_r[i][CW];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         mode_q <= '0;
         y_q    <= '0;
         sat_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
         mode_q <= mode_d;
         y_q    <= y_d;
         sat_q  <= sat_d;
      end
   end

   assign io.y   = y_q;
   assign io.sat = sat_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_count
      assign io.count[g*CW +: CW] = cnt_q[g];
   end
endmodule

// File: tb/tb_stoch_sat_addsub_multi.sv
// Bench for stoch_sat_addsub_multi: an 8-bit and a 2-bit counter instance share one stimulus.
// Directed hand-computed steps, then a randomised run against a behavioural lane model.
module tb_stoch_sat_addsub_multi;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   stoch_sat_addsub_multi_if #(.NUM_CH(4), .COUNTER_SIZE(8)) bus8 ();
   stoch_sat_addsub_multi_if #(.NUM_CH(4), .COUNTER_SIZE(2)) bus2 ();

   assign bus2.EN      = bus8.EN;
   assign bus2.MODE    = bus8.MODE;
   assign bus2.a       = bus8.a;
   assign bus2.b       = bus8.b;
   assign bus2.CLR_SAT = bus8.CLR_SAT;

   stoch_sat_addsub_multi #(.NUM_CH(4), .COUNTER_SIZE(8)) dut8 (.CLK(clk), .RST(rst), .io(bus8));
   stoch_sat_addsub_multi #(.NUM_CH(4), .COUNTER_SIZE(2)) dut2 (.CLK(clk), .RST(rst), .io(bus2));

   // Behavioural model: index 0 = 8-bit instance, index 1 = 2-bit instance.
   int mc [2][4];
   bit ms [2][4];
   bit my [2][4];
   bit mq [2][4];
   int mx [2] = '{255, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit en, input logic [3:0] md,
                             input logic [3:0] a, input logic [3:0] b, input logic [3:0] clr);
      int c;
      bit inc;
      bit yy;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            if (r) begin
               mc[k][i] = 0; ms[k][i] = 0; my[k][i] = 0; mq[k][i] = 0;
            end else begin
               if (clr[i]) ms[k][i] = 0;
               if (!en) begin
                  my[k][i] = 0;
               end else begin
                  c   = (md[i] != mq[k][i]) ? 0 : mc[k][i];
                  inc = 0;
                  yy  = 0;
                  case ({md[i], a[i], b[i]})
                     3'b010: if (c == 0) yy = 1; else c = c - 1;
                     3'b001: inc = 1;
                     3'b111: begin yy = 1; inc = 1; end
                     3'b110, 3'b101: yy = 1;
                     3'b100: if (c > 0) begin yy = 1; c = c - 1; end
                     default: yy = 0;
                  endcase
                  if (inc) begin
                     if (c == mx[k]) ms[k][i] = 1;
                     else            c = c + 1;
                  end
                  mc[k][i] = c;
                  my[k][i] = yy;
                  mq[k][i] = md[i];
               end
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit en, input logic [3:0] md,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] clr);
      rst          = r;
      bus8.EN      = en;
      bus8.MODE    = md;
      bus8.a       = a;
      bus8.b       = b;
      bus8.CLR_SAT = clr;
      @(posedge clk);
      model_step(r, en, md, a, b, clr);
      #1;
   endtask

   initial begin
      logic [3:0]  sub_a [5] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
      logic [3:0]  sub_b [5] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      logic        sub_y [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int          sub_c [5] = '{1, 2, 1, 0, 0};
      logic [3:0]  add_ab[5] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
      logic        add_y [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int          add_c [5] = '{1, 2, 1, 0, 0};
      int          sat_c [4] = '{1, 2, 3, 3};
      logic [31:0] ec8;
      logic [7:0]  ec2;
      logic [3:0]  ey8, es8, ey2, es2;
      logic [3:0]  ra, rb, rc;
      bit          ren;
      int          na [4], nb [4], nen [4], ones [4];
      int          ideal, diff;

      // Reset with operands active and EN high: reset must win.
      step(1, 1, 4'h0, 4'hF, 4'hF, 4'h0);
      step(1, 1, 4'h0, 4'hF, 4'hF, 4'h0);
      chk("rst_y", bus8.y, 0);
      chk("rst_sat", bus8.sat, 0);
      chk("rst_count", bus8.count, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 4'h0, 4'hF, 4'hF, 4'h0);
         chk("idle_y", bus8.y, 0);
         chk("idle_count", bus8.count, 0);
         chk("idle_sat", {bus8.sat, bus2.sat}, 0);
      end

      // Subtract on lane 0.
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 4'h0, sub_a[k], sub_b[k], 4'h0);
         chk("sub_y", bus8.y, {3'b0, sub_y[k]});
         chk("sub_count", bus8.count, sub_c[k]);
      end

      // Add on lane 1.
      step(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 4'h2, add_ab[k], add_ab[k], 4'h0);
         chk("add_y", bus8.y, {2'b0, add_y[k], 1'b0});
         chk("add_count1", bus8.count[15:8], add_c[k]);
      end

      // Saturation on the 2-bit instance, lane 0.
      step(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 4'h0, 4'h0, 4'h1, 4'h0);
         chk("sat_count2", bus2.count[1:0], sat_c[k]);
         chk("sat_flag2", bus2.sat, (k == 3) ? 1 : 0);
      end
      chk("nosat_count8", bus8.count[7:0], 4);
      chk("nosat_flag8", bus8.sat, 0);
      step(0, 1, 4'h0, 4'h0, 4'h0, 4'h1);
      chk("clr_flag2", bus2.sat, 0);
      chk("clr_count2", bus2.count[1:0], 3);
      step(0, 1, 4'h0, 4'h0, 4'h1, 4'h1);
      chk("set_wins_flag2", bus2.sat, 1);
      chk("set_wins_count2", bus2.count[1:0], 3);

      // Mode switch on lane 2, with an EN-low hold first.
      step(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 0; k < 3; k++) step(0, 1, 4'h0, 4'h0, 4'h4, 4'h0);
      chk("pre_switch_count2", bus8.count[23:16], 3);
      step(0, 0, 4'h0, 4'h4, 4'h0, 4'h0);
      chk("en_hold_count", bus8.count[23:16], 3);
      chk("en_hold_y", bus8.y, 0);
      step(0, 1, 4'h4, 4'h0, 4'h0, 4'h0);
      chk("switch_y", bus8.y, 0);
      chk("switch_count", bus8.count[23:16], 0);

      // Randomised run, fixed mixed modes, one reset pulse at cycle 100.
      for (int i = 0; i < 4; i++) begin na[i] = 0; nb[i] = 0; nen[i] = 0; ones[i] = 0; end
      for (int cyc = 0; cyc < 1000; cyc++) begin
         ren = ($urandom_range(0, 3) != 0);
         ra  = 4'($urandom);
         rb  = 4'($urandom);
         rc  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         step(cyc == 100, ren, 4'b0101, ra, rb, rc);
         for (int i = 0; i < 4; i++) begin
            ey8[i] = my[0][i]; es8[i] = ms[0][i]; ec8[i*8 +: 8] = 8'(mc[0][i]);
            ey2[i] = my[1][i]; es2[i] = ms[1][i]; ec2[i*2 +: 2] = 2'(mc[1][i]);
         end
         chk("rnd_y8", bus8.y, ey8);
         chk("rnd_sat8", bus8.sat, es8);
         chk("rnd_count8", bus8.count, ec8);
         chk("rnd_y2", bus2.y, ey2);
         chk("rnd_sat2", bus2.sat, es2);
         chk("rnd_count2", bus2.count, ec2);
         if (cyc > 100 && ren) begin
            for (int i = 0; i < 4; i++) begin
               na[i]   += ra[i];
               nb[i]   += rb[i];
               nen[i]  += 1;
               ones[i] += bus8.y[i];
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 1) ideal = (na[i] > nb[i]) ? na[i] - nb[i] : 0;
         else            ideal = (na[i] + nb[i] < nen[i]) ? na[i] + nb[i] : nen[i];
         diff = (ones[i] > ideal) ? ones[i] - ideal : ideal - ones[i];
         chk("ones_within_tol", diff <= 256, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
